// File: rtl/tapsig_logger.sv
// JTAG TAP signal-change logger: synchronizes the TAP byte, detects changes and
// streams {timestamp, tapsigs} records to a RAM. Optional ring-buffer mode via LOGGER_WRAP_EN.
module tapsig_logger #(
  parameter int ADDR_W = 14,
  parameter int TS_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        tapsigs_in,
  input  logic              arm,
  input  logic [7:0]        trig_mask,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [1:0]        state_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOGGING = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic [7:0]          r_sync_p0;
  logic [7:0]          r_sync_p1;
  logic [7:0]          r_prev;
  logic [TS_W-1:0]     r_ts;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                r_ovf;

  logic w_chg;
  logic w_trig;
  logic w_last;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [31:0] pack_rec(input logic [TS_W-1:0] ts, input logic [7:0] sig);
    return {24'(ts), sig};
  endfunction

  assign w_chg  = (r_sync_p1 != r_prev);
  assign w_trig = |((r_sync_p1 ^ r_prev) & trig_mask);

`ifdef LOGGER_WRAP_EN
  assign w_last = 1'b0;
`else
  localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
  // The write committing the final slot closes the buffer on the following edge
  assign w_last = r_wr_en && (r_count == CNT_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_prev    <= '0;
      r_ts      <= '0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      // stage p0/p1: two-flop synchronizer for the asynchronous TAP byte
      r_sync_p0 <= tapsigs_in;
      r_sync_p1 <= r_sync_p0;
      r_wr_en   <= 1'b0;

      // address/count advance the cycle after each strobe
      if (r_wr_en) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= sat_inc(r_count);
`ifdef LOGGER_WRAP_EN
        if (r_addr == {ADDR_W{1'b1}}) r_full <= 1'b1;
`endif
      end

      if (!arm) begin
        r_state <= IDLE;
        r_prev  <= r_sync_p1;
        r_addr  <= '0;
        r_count <= '0;
        r_full  <= 1'b0;
        r_ts    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_prev  <= r_sync_p1;
            r_addr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ts    <= '0;
            r_ovf   <= 1'b0;
            r_state <= ARMED;
          end
          ARMED: begin
            r_prev <= r_sync_p1;
            if (w_trig) begin
              r_wr_en <= 1'b1;
              r_data  <= pack_rec('0, r_sync_p1);
              r_ts    <= {{(TS_W-1){1'b0}}, 1'b1};
              r_state <= LOGGING;
            end
          end
          LOGGING: begin
            r_ts <= r_ts + 1'b1;
            if (w_last) begin
              r_state <= DONE;
              r_full  <= 1'b1;
              if (w_chg) begin
                r_ovf  <= 1'b1;
                r_prev <= r_sync_p1;
              end
            end else if (w_chg) begin
              r_wr_en <= 1'b1;
              r_data  <= pack_rec(r_ts, r_sync_p1);
              r_prev  <= r_sync_p1;
            end
          end
          DONE: begin
            if (w_chg) begin
              r_ovf  <= 1'b1;
              r_prev <= r_sync_p1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_addr;
  assign wr_data   = r_data;
  assign state_out = r_state;
  assign count     = r_count;
  assign full      = r_full;
  assign overflow  = r_ovf;

endmodule
